// File: rtl/tcn_step_addr_gen.sv
// Logical address sequencer for one TCN incremental step: read sweep 0..rd_len-1, write burst at wr_base, then pointer-update pulse.
// Reads stall on rd_ready; writes follow wr_valid_in with zero latency; full-rate step period is rd_len + wr_bs + 3 cycles.
module tcn_step_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] total_blocks,
  input  logic [31:0]       block_size,
  input  logic              rd_ready,
  input  logic              wr_valid_in,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_enable,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_enable,
  output logic              update_pointer,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_UPDATE = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] rd_len;
  logic [ADDR_W-1:0] wr_base;
  logic [15:0]       wr_cnt;
  logic [15:0]       wr_bs;
  logic              wr_ok;
  logic              done_r;

  logic [ADDR_W-1:0] rd_len_in;
  logic [ADDR_W-1:0] wr_base_in;
  logic              wr_ok_in;
  logic              rd_last;
  logic              wr_last;

  // Step geometry is derived from the live inputs only at the start handshake, then frozen.
  assign rd_len_in  = total_blocks * ADDR_W'(block_size[15:0]);
  assign wr_base_in = (total_blocks - ADDR_W'(1)) * ADDR_W'(block_size[31:16]);
  assign wr_ok_in   = (total_blocks != '0) && (block_size[31:16] != 16'd0);

  assign rd_last = (rd_cnt == rd_len - ADDR_W'(1));
  assign wr_last = (wr_cnt == wr_bs - 16'd1);

  always_comb begin
    state_nxt      = state;
    rd_enable      = 1'b0;
    wr_enable      = 1'b0;
    update_pointer = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (rd_len_in != '0) begin
            state_nxt = S_READ;
          end else if (wr_ok_in) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_UPDATE;
          end
        end
      end
      S_READ: begin
        rd_enable = 1'b1;
        if (rd_ready && rd_last) begin
          state_nxt = wr_ok ? S_WRITE : S_UPDATE;
        end
      end
      S_WRITE: begin
        wr_enable = wr_valid_in;
        if (wr_valid_in && wr_last) begin
          state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        update_pointer = 1'b1;
        state_nxt      = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      rd_len  <= '0;
      wr_base <= '0;
      wr_cnt  <= 16'd0;
      wr_bs   <= 16'd0;
      wr_ok   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == S_SETTLE);
      if (state == S_IDLE && start) begin
        rd_len  <= rd_len_in;
        wr_base <= wr_base_in;
        wr_bs   <= block_size[31:16];
        wr_ok   <= wr_ok_in;
        rd_cnt  <= '0;
        wr_cnt  <= 16'd0;
      end else begin
        if (rd_enable && rd_ready) begin
          rd_cnt <= rd_cnt + ADDR_W'(1);
        end
        if (wr_enable) begin
          wr_cnt <= wr_cnt + 16'd1;
        end
      end
    end
  end

  assign rd_address = rd_cnt;
  assign wr_address = wr_base + ADDR_W'(wr_cnt);
  assign busy       = (state != S_IDLE);
  assign done       = done_r;

  // The three strobes belong to disjoint phases of the step.
  assert property (@(posedge clk) disable iff (!reset)
    $onehot0({rd_enable, wr_enable, update_pointer}));
  assert property (@(posedge clk) disable iff (!reset) done |-> !busy);

endmodule

// File: tb/tb_tcn_step_addr_gen.sv
// Bench for tcn_step_addr_gen: directed vector table, corner sequences, and random traffic against a count-based step model.
module tb_tcn_step_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] total_blocks;
  logic [31:0] block_size;
  logic        rd_ready;
  logic        wr_valid_in;
  logic [15:0] rd_address;
  logic        rd_enable;
  logic [15:0] wr_address;
  logic        wr_enable;
  logic        update_pointer;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc_no = 0;

  // Step model: how many reads/writes remain, plus the two trailing cycles.
  bit m_busy, m_done;
  int m_rd_len, m_wr_n, m_base, m_rd_acc, m_wr_acc, m_post;

  bit          o_rd_acc, o_wr, o_upd, o_done;
  logic [15:0] o_wr_addr;

  typedef struct {
    logic [15:0] tb;
    logic [31:0] bs;
    int          rmode;
    int          wmode;
    int          cyc;
    int          nrd;
    int          nwr;
    logic [15:0] fw;
  } vec_t;

  vec_t vecs[8];

  tcn_step_addr_gen #(.ADDR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .total_blocks   (total_blocks),
    .block_size     (block_size),
    .rd_ready       (rd_ready),
    .wr_valid_in    (wr_valid_in),
    .rd_address     (rd_address),
    .rd_enable      (rd_enable),
    .wr_address     (wr_address),
    .wr_enable      (wr_enable),
    .update_pointer (update_pointer),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_rd_acc = 0; m_wr_acc = 0; m_post = 0;
    m_rd_len = 0; m_wr_n = 0; m_base = 0;
  endtask

  // Called at posedge+1: drive, compare at negedge, advance model at the next posedge.
  task automatic tick(input bit s, input bit rr, input bit wv);
    logic [4:0] exp_ctrl;
    bit         in_rd, in_wr;
    longint     p;
    start = s; rd_ready = rr; wr_valid_in = wv;
    @(negedge clk);
    cyc_no++;
    in_rd = m_busy && (m_rd_acc < m_rd_len);
    in_wr = m_busy && !in_rd && (m_wr_acc < m_wr_n);
    exp_ctrl = {in_rd, in_wr && wv, m_busy && !in_rd && !in_wr && (m_post == 0),
                m_busy, !m_busy && m_done};
    check($sformatf("cyc%0d ctrl{rd,wr,upd,busy,done}", cyc_no),
          {27'd0, rd_enable, wr_enable, update_pointer, busy, done}, {27'd0, exp_ctrl});
    if (in_rd) check($sformatf("cyc%0d rd_address", cyc_no), {16'd0, rd_address}, 32'(m_rd_acc));
    if (in_wr) check($sformatf("cyc%0d wr_address", cyc_no), {16'd0, wr_address},
                     32'((m_base + m_wr_acc) % 65536));
    o_rd_acc = rd_enable && rr; o_wr = wr_enable; o_wr_addr = wr_address;
    o_upd = update_pointer; o_done = done;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (!m_busy) begin
      m_done = 0;
      if (s) begin
        p = longint'(total_blocks) * longint'(block_size[15:0]);
        m_rd_len = int'(p % 65536);
        m_wr_n = (total_blocks == 16'd0) ? 0 : int'(block_size[31:16]);
        p = (total_blocks == 16'd0) ? 0 : (longint'(total_blocks) - 1) * longint'(block_size[31:16]);
        m_base = int'(p % 65536);
        m_busy = 1; m_rd_acc = 0; m_wr_acc = 0; m_post = 0;
      end
    end else if (m_rd_acc < m_rd_len) begin
      if (rr) m_rd_acc++;
    end else if (m_wr_acc < m_wr_n) begin
      if (wv) m_wr_acc++;
    end else if (m_post == 0) begin
      m_post = 1;
    end else begin
      m_busy = 0; m_done = 1;
    end
    #1;
  endtask

  task automatic run_vec(input int i);
    int          cyc, nrd, nwr, nupd;
    logic [15:0] fw;
    bit          rr, wv;
    total_blocks = vecs[i].tb; block_size = vecs[i].bs;
    tick(1'b1, 1'b0, 1'b0);
    cyc = -1; nrd = 0; nwr = 0; nupd = 0; fw = 16'd0;
    for (int k = 1; k <= 200; k++) begin
      rr = (vecs[i].rmode == 0) ? 1'b1 : (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      wv = (vecs[i].wmode == 0) ? 1'b1 : (k % 4 == 0);
      tick(1'b0, rr, wv);
      if (o_rd_acc) nrd++;
      if (o_wr) begin
        if (nwr == 0) fw = o_wr_addr;
        nwr++;
      end
      if (o_upd) nupd++;
      if (o_done) begin
        cyc = k;
        break;
      end
    end
    check($sformatf("vec%0d cycles to done", i), 32'(cyc), 32'(vecs[i].cyc));
    check($sformatf("vec%0d read count", i), 32'(nrd), 32'(vecs[i].nrd));
    check($sformatf("vec%0d write count", i), 32'(nwr), 32'(vecs[i].nwr));
    check($sformatf("vec%0d first wr addr", i), {16'd0, fw}, {16'd0, vecs[i].fw});
    check($sformatf("vec%0d update pulses", i), 32'(nupd), 32'd1);
  endtask

  task automatic drain();
    for (int j = 0; j < 400 && (m_busy || m_done); j++) tick(1'b0, 1'b1, 1'b1);
    check("drain idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    int nupd;
    int sel;
    //            tb        block_size    rmode wmode cyc nrd nwr first_wr
    vecs[0] = '{16'd4,      32'h0002_0003, 0, 0, 17, 12, 2, 16'd6};
    vecs[1] = '{16'd4,      32'h0002_0003, 1, 0, 29, 12, 2, 16'd6};
    vecs[2] = '{16'd4,      32'h0002_0003, 0, 1, 23, 12, 2, 16'd6};
    vecs[3] = '{16'd0,      32'h0002_0003, 0, 0,  3,  0, 0, 16'd0};
    vecs[4] = '{16'd3,      32'h0000_0002, 0, 0,  9,  6, 0, 16'd0};
    vecs[5] = '{16'd5,      32'h0003_0000, 0, 0,  6,  0, 3, 16'd12};
    vecs[6] = '{16'h8000,   32'h0001_0002, 0, 0,  4,  0, 1, 16'h7FFF};
    vecs[7] = '{16'd1,      32'h0001_0001, 0, 0,  5,  1, 1, 16'd0};

    reset = 1'b0; start = 1'b0; rd_ready = 1'b0; wr_valid_in = 1'b0;
    total_blocks = 16'd0; block_size = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_address", {16'd0, rd_address}, 32'd0);
    check("reset wr_address", {16'd0, wr_address}, 32'd0);
    check("reset ctrl", {27'd0, rd_enable, wr_enable, update_pointer, busy, done}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset after five accepted reads.
    total_blocks = 16'd4; block_size = 32'h0002_0003;
    tick(1'b1, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    check("midreset rd_address", {16'd0, rd_address}, 32'd0);
    check("midreset wr_address", {16'd0, wr_address}, 32'd0);
    check("midreset ctrl", {27'd0, rd_enable, wr_enable, update_pointer, busy, done}, 32'd0);
    model_reset();
    nupd = 0;
    for (int j = 0; j < 3; j++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (o_upd) nupd++;
    end
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (o_upd) nupd++;
    end
    check("midreset update pulses", 32'(nupd), 32'd0);
    run_vec(0);

    // start held high: exactly one step per done, restart taken in the done cycle.
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (o_done) ndone++;
    end
    check("start-held done count", 32'(ndone), 32'd2);
    drain();

    // Random traffic, random config churn mid-step, random start while busy.
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 7));
        total_blocks = (sel == 7) ? 16'h8000 : 16'(sel);
        block_size[15:0]  = (sel == 7) ? 16'(2 * $urandom_range(0, 1)) : 16'($urandom_range(0, 3));
        block_size[31:16] = 16'($urandom_range(0, 3));
      end
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
